// File: rtl/mole_controller.sv
// mole_controller
//   Takes the periodic spawn pulse, lights one pseudo-randomly chosen hole for
//   a lifetime set by the difficulty, and watches the hole buttons. Each
//   outcome is reported as a one-cycle hit or miss pulse.
//
//   Optional feature macro: MOLE_WRONG_PRESS_EN
//     defined   - a rising edge on any unlit hole ends the mole as a miss
//     undefined - unlit-hole presses are ignored
//
//   Ports:
//     CLK100MHZ   in   system clock
//     n_reset     in   asynchronous active-low reset
//     enable      in   one-cycle spawn pulse
//     difficulty  in   00/01/10 select LIFE0/1/2, 11 = game off
//     buttons     in   debounced, synchronised button levels, one per hole
//     mole        out  one-hot lit hole, or all zero
//     hole_idx    out  index of the current or last mole
//     busy        out  high while a mole is up
//     hit         out  one-cycle pulse when the lit hole is pressed
//     miss        out  one-cycle pulse on timeout (or wrong press if enabled)
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | no mole lit; an enable pulse with difficulty != 11 spawns
//   S_UP   | mole lit; lifetime down-counter running, buttons watched
module mole_controller #(
  parameter int NUM_HOLES = 9,
  parameter int LIFE0     = 150_000_000,
  parameter int LIFE1     = 90_000_000,
  parameter int LIFE2     = 60_000_000
) (
  input  logic                 CLK100MHZ,
  input  logic                 n_reset,
  input  logic                 enable,
  input  logic [1:0]           difficulty,
  input  logic [NUM_HOLES-1:0] buttons,
  output logic [NUM_HOLES-1:0] mole,
  output logic [3:0]           hole_idx,
  output logic                 busy,
  output logic                 hit,
  output logic                 miss
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_UP   = 1'b1
  } state_t;

  localparam logic [4:0]           NH5       = 5'(NUM_HOLES);
  localparam logic [3:0]           NH4       = 4'(NUM_HOLES);
  localparam logic [27:0]          LIFE0_M1  = 28'(LIFE0 - 1);
  localparam logic [27:0]          LIFE1_M1  = 28'(LIFE1 - 1);
  localparam logic [27:0]          LIFE2_M1  = 28'(LIFE2 - 1);
  localparam logic [15:0]          LFSR_SEED = 16'hACE1;
  localparam logic [NUM_HOLES-1:0] ONE_HOT0  = {{(NUM_HOLES-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [27:0]          cnt_q, cnt_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic [NUM_HOLES-1:0] btn_prev_q, btn_prev_d;
  logic [NUM_HOLES-1:0] mole_q, mole_d;
  logic [3:0]           hole_idx_q, hole_idx_d;
  logic                 busy_q, busy_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;

  logic [NUM_HOLES-1:0] btn_edge;
  logic                 correct_edge;
  logic                 wrong_edge;
  logic [3:0]           cand_wrap;
  logic [3:0]           new_idx;
  logic [27:0]          life_m1;

  // Fibonacci LFSR, taps 16,14,13,11; free-running, never reaches zero
  // because it starts from a nonzero seed.
  always_comb begin
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    btn_prev_d = buttons;
  end

  assign btn_edge     = buttons & ~btn_prev_q;
  // mole_q is one-hot on hole_idx while UP and zero in IDLE.
  assign correct_edge = |(btn_edge & mole_q);

`ifdef MOLE_WRONG_PRESS_EN
  assign wrong_edge = |(btn_edge & ~mole_q);
`else
  assign wrong_edge = 1'b0;
`endif

  // Candidate hole: low nibble folded once into range (nibble < 16 <= 2*NUM_HOLES),
  // then bumped by one if it would repeat the previous hole.
  always_comb begin
    cand_wrap = lfsr_q[3:0];
    if ({1'b0, lfsr_q[3:0]} >= NH5) begin
      cand_wrap = lfsr_q[3:0] - NH4;
    end
    new_idx = cand_wrap;
    if (cand_wrap == hole_idx_q) begin
      if (({1'b0, cand_wrap} + 5'd1) == NH5) begin
        new_idx = 4'd0;
      end else begin
        new_idx = cand_wrap + 4'd1;
      end
    end
  end

  always_comb begin
    case (difficulty)
      2'b00:   life_m1 = LIFE0_M1;
      2'b01:   life_m1 = LIFE1_M1;
      default: life_m1 = LIFE2_M1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mole_d     = mole_q;
    hole_idx_d = hole_idx_q;
    busy_d     = busy_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && (difficulty != 2'b11)) begin
          cnt_d      = life_m1;
          hole_idx_d = new_idx;
          mole_d     = ONE_HOT0 << new_idx;
          busy_d     = 1'b1;
          state_d    = S_UP;
        end
      end
      S_UP: begin
        // Enable pulses are not looked at here, so they are dropped.
        if (correct_edge) begin
          hit_d   = 1'b1;
          mole_d  = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (wrong_edge) begin
          miss_d  = 1'b1;
          mole_d  = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == 28'd0) begin
          miss_d  = 1'b1;
          mole_d  = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 28'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        mole_d  = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      // All-ones so a button held through reset does not look like a press.
      btn_prev_q <= '1;
      mole_q     <= '0;
      hole_idx_q <= '0;
      busy_q     <= 1'b0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lfsr_q     <= lfsr_d;
      btn_prev_q <= btn_prev_d;
      mole_q     <= mole_d;
      hole_idx_q <= hole_idx_d;
      busy_q     <= busy_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  assign mole     = mole_q;
  assign hole_idx = hole_idx_q;
  assign busy     = busy_q;
  assign hit      = hit_q;
  assign miss     = miss_q;

endmodule

// File: tb/tb_mole_controller.sv
module tb_mole_controller;
  localparam int NH = 9;

  logic          clk        = 1'b0;
  logic          n_reset    = 1'b1;
  logic          enable     = 1'b0;
  logic [1:0]    difficulty = 2'b00;
  logic [NH-1:0] buttons    = '0;
  logic [NH-1:0] mole;
  logic [3:0]    hole_idx;
  logic          busy, hit, miss;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mole_controller #(
    .NUM_HOLES(NH),
    .LIFE0(10),
    .LIFE1(6),
    .LIFE2(4)
  ) dut (
    .CLK100MHZ (clk),
    .n_reset   (n_reset),
    .enable    (enable),
    .difficulty(difficulty),
    .buttons   (buttons),
    .mole      (mole),
    .hole_idx  (hole_idx),
    .busy      (busy),
    .hit       (hit),
    .miss      (miss)
  );

  // Reference model: a mole is a (hole, deadline cycle) pair; outcomes are
  // decided by comparing the cycle number with the deadline.
  logic [NH-1:0] m_prev;
  logic [15:0]   m_lfsr;
  logic          m_up;
  int            m_idx;
  int            m_deadline;
  int            m_cyc;
  logic          m_spawned;

  logic [NH-1:0] e_mole;
  logic [3:0]    e_idx;
  logic          e_busy, e_hit, e_miss;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & 16'hB400)};
  endfunction

  function automatic int life_of(input logic [1:0] d);
    return (d == 2'd0) ? 10 : (d == 2'd1) ? 6 : 4;
  endfunction

  function automatic logic [15:0] dut_vec();
    return {mole, hole_idx, busy, hit, miss};
  endfunction

  function automatic logic [15:0] exp_vec();
    return {e_mole, e_idx, e_busy, e_hit, e_miss};
  endfunction

  task automatic model_reset();
    m_up = 1'b0; m_idx = 0; m_cyc = 0; m_deadline = 0;
    m_lfsr = 16'hACE1; m_prev = '1; m_spawned = 1'b0;
  endtask

  // Drive one cycle of inputs, predict the outputs after the next rising
  // edge, then return 1 time unit after that edge.
  task automatic tick(input logic en, input logic [1:0] d, input logic [NH-1:0] b);
    logic [NH-1:0] edges;
    int c;
    enable = en; difficulty = d; buttons = b;
    edges = b & ~m_prev;
    e_hit = 1'b0; e_miss = 1'b0; m_spawned = 1'b0;
    if (m_up) begin
      if (edges[m_idx]) begin
        e_hit = 1'b1; m_up = 1'b0;
      end
`ifdef MOLE_WRONG_PRESS_EN
      else if (edges != '0) begin
        e_miss = 1'b1; m_up = 1'b0;
      end
`endif
      else if (m_cyc == m_deadline) begin
        e_miss = 1'b1; m_up = 1'b0;
      end
    end else if (en && d != 2'b11) begin
      c = int'(m_lfsr[3:0]) % NH;
      if (c == m_idx) c = (c + 1) % NH;
      m_idx = c; m_up = 1'b1; m_spawned = 1'b1;
      m_deadline = m_cyc + life_of(d);
    end
    m_prev = b;
    m_lfsr = lfsr_next(m_lfsr);
    m_cyc++;
    e_mole = m_up ? (9'd1 << m_idx) : '0;
    e_idx  = 4'(m_idx);
    e_busy = m_up;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    buttons = '0; enable = 1'b0; difficulty = 2'b00;
    #2 n_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dut_vec() !== 16'h0) begin
      errors++; $display("FAIL reset_values got=%h exp=0000", dut_vec());
    end
    @(negedge clk); n_reset = 1'b1; model_reset();
    repeat (3) begin
      tick(1'b0, 2'b00, '0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_idle got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_timeout();
    int  lit;
    bit  done;
    lit = 0; done = 0;
    tick(1'b1, 2'b00, '0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL timeout_spawn got=%h exp=%h", dut_vec(), exp_vec());
    end
    if (mole != '0) lit++;
    for (int i = 0; i < 30 && !done; i++) begin
      tick(1'b0, 2'b00, '0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL timeout_cycle got=%h exp=%h", dut_vec(), exp_vec());
      end
      if (mole != '0) lit++;
      if (miss === 1'b1) begin
        done = 1;
        checks++;
        if (busy !== 1'b0 || mole !== '0) begin
          errors++; $display("FAIL timeout_busy_drop busy=%b mole=%h exp busy=0 mole=0", busy, mole);
        end
      end
    end
    checks++;
    if (!done || lit != 10) begin
      errors++; $display("FAIL timeout_lit_cycles got=%0d exp=10 (miss seen=%0d)", lit, done);
    end
    tick(1'b0, 2'b00, '0);
    checks++;
    if (miss !== 1'b0) begin
      errors++; $display("FAIL timeout_miss_width got=%b exp=0", miss);
    end
  endtask

  task automatic test_hit();
    logic [NH-1:0] b;
    tick(1'b1, 2'b10, '0);
    tick(1'b0, 2'b10, '0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL hit_pre got=%h exp=%h", dut_vec(), exp_vec());
    end
    b = 9'd1 << m_idx;
    tick(1'b0, 2'b10, b);
    checks++;
    if (hit !== 1'b1 || mole !== '0 || miss !== 1'b0) begin
      errors++; $display("FAIL hit_pulse got hit=%b mole=%h miss=%b exp hit=1 mole=0 miss=0", hit, mole, miss);
    end
    repeat (8) begin
      tick(1'b0, 2'b10, b);
      checks++;
      if (dut_vec() !== exp_vec() || miss !== 1'b0 || hit !== 1'b0) begin
        errors++; $display("FAIL hit_after got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    tick(1'b0, 2'b10, '0);
  endtask

  task automatic test_simultaneous();
    int idx;
    tick(1'b1, 2'b10, '0);
    idx = m_idx;
    repeat (3) begin
      tick(1'b0, 2'b10, '0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL simul_wait got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    tick(1'b0, 2'b10, 9'd1 << idx);
    checks++;
    if (hit !== 1'b1 || miss !== 1'b0) begin
      errors++; $display("FAIL simul_hit_over_timeout got hit=%b miss=%b exp hit=1 miss=0", hit, miss);
    end
    tick(1'b0, 2'b10, '0);
    tick(1'b1, 2'b10, '0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 2'b10, '0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL simul_enable_up got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    checks++;
    if (miss !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL simul_exit got miss=%b busy=%b exp miss=1 busy=0", miss, busy);
    end
    repeat (6) begin
      tick(1'b0, 2'b10, '0);
      checks++;
      if (busy !== 1'b0 || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL simul_no_queued_spawn got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_index();
    int            spawns;
    int            prev;
    logic [NH-1:0] seen;
    logic [NH-1:0] b;
    logic          en;
    logic [1:0]    d;
    spawns = 0; prev = int'(hole_idx); seen = '0; b = '0;
    for (int i = 0; i < 6000 && spawns < 200; i++) begin
      en = ($urandom_range(0, 2) == 0);
      d  = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) b = b ^ (9'd1 << $urandom_range(0, NH - 1));
      tick(en, d, b);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL index_model got=%h exp=%h", dut_vec(), exp_vec());
      end
      if (m_spawned) begin
        spawns++;
        checks++;
        if (int'(hole_idx) >= NH || int'(hole_idx) == prev) begin
          errors++; $display("FAIL index_rule got=%0d prev=%0d exp <%0d and != prev", hole_idx, prev, NH);
        end
        prev = int'(hole_idx);
        if (int'(hole_idx) < NH) seen[hole_idx] = 1'b1;
      end
    end
    checks++;
    if (spawns < 200) begin
      errors++; $display("FAIL index_spawn_count got=%0d exp=200", spawns);
    end
    checks++;
    if (seen !== '1) begin
      errors++; $display("FAIL index_coverage got=%b exp=%b", seen, {NH{1'b1}});
    end
    repeat (12) tick(1'b0, 2'b00, '0);
  endtask

  task automatic test_game_off();
    repeat (40) begin
      tick(1'($urandom_range(0, 1)), 2'b11, '0);
      checks++;
      if (busy !== 1'b0 || mole !== '0 || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL game_off got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_wrong_press();
    int            w;
    logic [NH-1:0] b;
    tick(1'b1, 2'b00, '0);
    w = (m_idx + 1) % NH;
    b = 9'd1 << w;
    tick(1'b0, 2'b00, '0);
    tick(1'b0, 2'b00, b);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL wrong_press_model got=%h exp=%h", dut_vec(), exp_vec());
    end
`ifdef MOLE_WRONG_PRESS_EN
    checks++;
    if (miss !== 1'b1 || hit !== 1'b0 || mole !== '0) begin
      errors++; $display("FAIL wrong_press_miss got miss=%b hit=%b mole=%h exp miss=1 hit=0 mole=0", miss, hit, mole);
    end
`else
    begin
      int lit;
      bit done;
      lit = (mole != '0) ? 3 : 0;
      done = 0;
      for (int i = 0; i < 20 && !done; i++) begin
        tick(1'b0, 2'b00, b);
        checks++;
        if (dut_vec() !== exp_vec()) begin
          errors++; $display("FAIL wrong_press_ignored got=%h exp=%h", dut_vec(), exp_vec());
        end
        if (mole != '0) lit++;
        if (miss === 1'b1) done = 1;
      end
      checks++;
      if (!done || lit != 10) begin
        errors++; $display("FAIL wrong_press_lifetime got=%0d exp=10", lit);
      end
    end
`endif
    repeat (2) tick(1'b0, 2'b00, '0);
  endtask

  task automatic test_reset_mid_up();
    tick(1'b1, 2'b01, '0);
    tick(1'b0, 2'b01, '0);
    checks++;
    if (busy !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_mid_up_pre got=%h exp=%h", dut_vec(), exp_vec());
    end
    #2 n_reset = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 16'h0) begin
      errors++; $display("FAIL reset_mid_up_async got=%h exp=0000", dut_vec());
    end
    @(negedge clk); n_reset = 1'b1; model_reset();
    repeat (3) begin
      tick(1'b0, 2'b01, '0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_mid_up_after got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_held_button();
    tick(1'b0, 2'b00, '1);
    #2 n_reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); n_reset = 1'b1; model_reset();
    tick(1'b1, 2'b00, '1);
    repeat (12) begin
      tick(1'b0, 2'b00, '1);
      checks++;
      if (hit !== 1'b0 || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL held_button got=%h exp=%h", dut_vec(), exp_vec());
      end
    end
    repeat (2) tick(1'b0, 2'b00, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    e_mole = '0; e_idx = '0; e_busy = 1'b0; e_hit = 1'b0; e_miss = 1'b0;
    test_reset();
    test_timeout();
    test_hit();
    test_simultaneous();
    test_index();
    test_game_off();
    test_wrong_press();
    test_reset_mid_up();
    test_held_button();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_controller.md
# mole_controller

Consumer of the periodic one-cycle spawn pulse from the difficulty-driven enable generator. On each accepted pulse it picks a pseudo-random hole, lights that mole for a difficulty-dependent lifetime, and watches the hole buttons. It reports each outcome as a one-cycle `hit` or `miss` pulse to the scoring logic. It sits between the spawn timer, the debounced button inputs and the LED/score datapath.

## Interface
Parameters:
- `NUM_HOLES`, default 9: number of holes. Legal range is 8..16.
- `LIFE0`, default 150_000_000: mole lifetime in cycles at difficulty 0 (1.5 s).
- `LIFE1`, default 90_000_000: lifetime in cycles at difficulty 1.
- `LIFE2`, default 60_000_000: lifetime in cycles at difficulty 2. All LIFEn must satisfy ≥2 and <2^28.

Ports:
- `CLK100MHZ`  in  1: system clock, 100 MHz.
- `n_reset`  in  1: asynchronous, active-low reset.
- `enable`  in  1: one-cycle spawn pulse.
- `difficulty`  in  2: 00/01/10 select LIFE0/1/2. 11 means game off.
- `buttons`  in  NUM_HOLES: debounced, already-synchronised button levels, one per hole.
- `mole`  out  NUM_HOLES: one-hot lit hole, or all zero.
- `hole_idx`  out  4: index of the current or last mole.
- `busy`  out  1: high while a mole is up.
- `hit`  out  1: one-cycle pulse when the mole is whacked.
- `miss`  out  1: one-cycle pulse when the mole times out (or on a wrong press, see Configuration).

## Operation
- **FSM states:** IDLE and UP.
- **IDLE:**
  - If `enable`=1 and `difficulty`≠11, the block latches the lifetime. Counter loads LIFEn−1, using `difficulty` sampled that cycle.
  - It latches the new index, sets `mole` one-hot and moves to UP.
  - With `difficulty`=11, `enable` is ignored.
- **UP:**
  - A button edge is `buttons & ~btn_prev`, where `btn_prev` is registered every cycle.
  - An edge on `buttons[hole_idx]` gives `hit`=1, `mole`=0 and a return to IDLE.
  - Otherwise, with counter==0: `miss`=1, `mole`=0, return to IDLE.
  - Otherwise the counter decrements.
  - Later changes to `difficulty` do not affect a running mole.
- **Index generation:**
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1. It free-runs every cycle and is never all-zero.
  - Candidate = `lfsr[3:0]`. If candidate ≥ NUM_HOLES, subtract NUM_HOLES.
  - If candidate equals the previous `hole_idx`, add 1 modulo NUM_HOLES. Consecutive moles therefore never share a hole.
- **Dropped pulses:** `enable` pulses arriving while in UP, including the cycle UP exits, are dropped and not queued.
- **Priority within one cycle:** correct-hole edge > wrong-hole edge > timeout.
- **Counter:** 28 bits, unsigned, no wrap. It is only decremented while nonzero.

## Timing
- **Reset values:**
  - Outputs: `mole`=0, `hole_idx`=0, `busy`=0, `hit`=0, `miss`=0.
  - Internal: FSM=IDLE, counter=0, LFSR=16'hACE1.
  - `btn_prev` resets to all-ones, so buttons held through reset produce no edge.
- **Reset mid-UP:** the mole clears immediately (asynchronous). No `hit` or `miss` is emitted.
- **Spawn latency:** `enable` high at edge N → `mole`, `busy` and `hole_idx` valid after edge N.
- **Timeout, no press:** `mole` stays high for exactly LIFEn cycles. `miss` is high for the one cycle following the last lit cycle, and `mole` is 0 in that same cycle.
- **Hit:** button rises before edge K while UP → after edge K, `hit`=1 and `mole`=0. `hit` lasts exactly 1 cycle.
- **Spawn at earliest:** the block can spawn on the cycle `hit` or `miss` is high, because it is already in IDLE.
- **Pulse width:** all outputs are registered. `hit` and `miss` are never both high and never high longer than one cycle.

## Configuration
- Macro: `MOLE_WRONG_PRESS_EN`.
- **Defined:** in UP, a rising edge on any hole other than `hole_idx` (with no correct edge in the same cycle) ends the mole as a miss, using the same timing as a hit.
- **Undefined:** wrong-hole presses are ignored, and only the correct press or the timeout ends the mole.

## Test plan
Use LIFE0=10, LIFE1=6, LIFE2=4, NUM_HOLES=9.
- **Timeout:** difficulty 00, single `enable` pulse, no presses → `mole` one-hot for exactly 10 cycles, then `miss`=1 for 1 cycle, `busy` falls with it.
- **Hit:** difficulty 10, spawn, then at cycle 2 rise `buttons[hole_idx]` → `hit` 1 cycle later, `mole`=0, no `miss` ever.
- **Simultaneous events and busy drop:**
  - Correct press landing on the timeout cycle → `hit` only.
  - `enable` pulsed while UP → ignored, with no second mole after exit.
- **Index sequence and game off:**
  - 200 spawns → `hole_idx` always < 9, never equal on consecutive spawns, every hole appears.
  - `difficulty`=11 → no spawns at all.
- **Wrong press, reset, held button:**
  - Wrong-hole press → `miss` with the macro defined, and no effect (mole times out at 10) without it.
  - `n_reset` low mid-UP → all outputs 0 immediately.
  - Button held through reset → no `hit`.
